// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port RAM window.
// Round-robin on ties, one accepted request per cycle, responses one cycle later.
module mem_arbiter #(
    parameter int unsigned BASE = 256,
    parameter int unsigned SIZE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    output logic        ram_mem_read,
    output logic        ram_mem_en,
    input  logic [31:0] ram_data_out
);

    localparam int unsigned AW = 32;
    // One extra bit so BASE+SIZE cannot wrap.
    localparam logic [AW:0] WIN_LO = (AW+1)'(BASE);
    localparam logic [AW:0] WIN_HI = (AW+1)'(BASE) + (AW+1)'(SIZE);

    logic          last_d;
    logic          gnt_i_c;
    logic          gnt_d_c;
    logic          accept_c;
    logic          in_win_c;
    logic [AW-1:0] sel_addr_c;
    logic [AW-1:0] rd_data_c;

    logic rsp_valid;
    logic rsp_port_d;
    logic rsp_write;
    logic rsp_err;

    // Grant: lone requester wins, ties go to the port not granted last.
    always_comb begin
        gnt_i_c = 1'b0;
        gnt_d_c = 1'b0;
        if (!rst) begin
            if (i_req_valid && (!d_req_valid || last_d)) begin
                gnt_i_c = 1'b1;
            end else if (d_req_valid) begin
                gnt_d_c = 1'b1;
            end
        end
    end

    assign accept_c    = gnt_i_c | gnt_d_c;
    assign i_req_ready = gnt_i_c;
    assign d_req_ready = gnt_d_c;
    assign sel_addr_c  = gnt_i_c ? i_addr : d_addr;
    assign in_win_c    = ({1'b0, sel_addr_c} >= WIN_LO) && ({1'b0, sel_addr_c} < WIN_HI);

    // RAM command driven straight from the accepted request.
    always_comb begin
        ram_addr     = '0;
        ram_data_in  = '0;
        ram_mem_read = 1'b0;
        ram_mem_en   = 1'b0;
        if (accept_c) begin
            ram_addr     = sel_addr_c;
            ram_mem_read = gnt_i_c ? 1'b1 : !d_we;
            ram_data_in  = gnt_d_c ? d_wdata : '0;
            ram_mem_en   = in_win_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (gnt_i_c) begin
            last_d <= 1'b0;
        end else if (gnt_d_c) begin
            last_d <= 1'b1;
        end
    end

    // Response context for the request accepted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_port_d <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid  <= accept_c;
            rsp_port_d <= gnt_d_c;
            rsp_write  <= gnt_d_c & d_we;
            rsp_err    <= accept_c & !in_win_c;
        end
    end

    assign rd_data_c   = (rsp_valid && !rsp_write && !rsp_err) ? ram_data_out : '0;
    assign i_rsp_valid = rsp_valid & !rsp_port_d;
    assign d_rsp_valid = rsp_valid & rsp_port_d;
    assign i_rsp_data  = i_rsp_valid ? rd_data_c : '0;
    assign d_rsp_data  = d_rsp_valid ? rd_data_c : '0;
    assign i_rsp_err   = i_rsp_valid & rsp_err;
    assign d_rsp_err   = d_rsp_valid & rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset sequences,
// with a small behavioural RAM answering the arbiter's RAM port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [31:0] ram_addr, ram_data_in, ram_data_out;
    logic        ram_mem_read, ram_mem_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.BASE(256), .SIZE(256)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_mem_read(ram_mem_read),
        .ram_mem_en(ram_mem_en), .ram_data_out(ram_data_out)
    );

    // Behavioural RAM: read data appears the cycle after the read issues.
    logic [31:0] mem [0:1023];
    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        ram_data_out = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_mem_en) begin
            if (ram_mem_read) ram_data_out <= mem[ram_addr[9:0]];
            else              mem[ram_addr[9:0]] <= ram_data_in;
        end
    end

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_ir;
        logic        e_dr;
        logic        e_en;
        logic        e_rd;
        logic        e_iv;
        logic [31:0] e_idata;
        logic        e_ierr;
        logic        e_dv;
        logic [31:0] e_ddata;
        logic        e_derr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [31:0] ia, logic dv, logic dwe,
                                logic [31:0] da, logic [31:0] dwd,
                                logic e_ir, logic e_dr, logic e_en, logic e_rd,
                                logic e_iv, logic [31:0] e_idata, logic e_ierr,
                                logic e_dv, logic [31:0] e_ddata, logic e_derr);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_en = e_en; v.e_rd = e_rd;
        v.e_iv = e_iv; v.e_idata = e_idata; v.e_ierr = e_ierr;
        v.e_dv = e_dv; v.e_ddata = e_ddata; v.e_derr = e_derr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        i_req_valid = iv; i_addr = ia;
        d_req_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    initial begin
        // Rows: inputs | ready_i ready_d en read | i_rsp v/data/err | d_rsp v/data/err
        vecs.push_back(mk(0,0,  1,1,300,32'hDEADBEEF, 0,1,1,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(1,300,0,0,0,0,              1,0,1,1, 0,0,0, 1,0,0));
        vecs.push_back(mk(0,0,  0,0,0,0,              0,0,0,0, 1,32'hDEADBEEF,0, 0,0,0));
        vecs.push_back(mk(0,0,  1,1,511,32'h1234,     0,1,1,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,  1,0,511,0,            0,1,1,1, 0,0,0, 1,0,0));
        vecs.push_back(mk(0,0,  0,0,0,0,              0,0,0,0, 0,0,0, 1,32'h1234,0));
        vecs.push_back(mk(0,0,  1,1,255,32'hFFFF,     0,1,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,  1,1,512,32'hFFFF,     0,1,0,0, 0,0,0, 1,0,1));
        vecs.push_back(mk(0,0,  1,0,255,0,            0,1,0,1, 0,0,0, 1,0,1));
        vecs.push_back(mk(0,0,  1,0,511,0,            0,1,1,1, 0,0,0, 1,0,1));
        vecs.push_back(mk(1,300,1,0,300,32'h5555,     1,0,1,1, 0,0,0, 1,32'h1234,0));
        vecs.push_back(mk(1,300,1,0,300,32'h5555,     0,1,1,1, 1,32'hDEADBEEF,0, 0,0,0));
        vecs.push_back(mk(1,300,1,0,300,32'h5555,     1,0,1,1, 0,0,0, 1,32'hDEADBEEF,0));
        vecs.push_back(mk(1,300,1,0,300,32'h5555,     0,1,1,1, 1,32'hDEADBEEF,0, 0,0,0));
        vecs.push_back(mk(0,0,  0,0,0,0,              0,0,0,0, 0,0,0, 1,32'hDEADBEEF,0));
        vecs.push_back(mk(1,0,  0,0,0,0,              1,0,0,1, 0,0,0, 0,0,0));
        vecs.push_back(mk(1,32'hFFFFFFFF,0,0,0,0,     1,0,0,1, 1,0,1, 0,0,0));
        vecs.push_back(mk(1,32'h0001012C,0,0,0,0,     1,0,0,1, 1,0,1, 0,0,0));
        vecs.push_back(mk(0,0,  0,0,0,0,              0,0,0,0, 1,0,1, 0,0,0));

        // Reset held with both ports requesting: nothing is granted.
        rst = 1'b1;
        drive(1, 300, 1, 1, 300, 32'h7);
        repeat (2) @(negedge clk);
        #1;
        check("rst_i_ready", 32'(i_req_ready), 0);
        check("rst_d_ready", 32'(d_req_ready), 0);
        check("rst_mem_en",  32'(ram_mem_en), 0);
        check("rst_rsp_v",   32'({i_rsp_valid, d_rsp_valid}), 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            vec_t v;
            v = vecs[n];
            @(negedge clk);
            drive(v.iv, v.ia, v.dv, v.dwe, v.da, v.dwd);
            #1;
            check($sformatf("v%0d_i_ready", n), 32'(i_req_ready), 32'(v.e_ir));
            check($sformatf("v%0d_d_ready", n), 32'(d_req_ready), 32'(v.e_dr));
            check($sformatf("v%0d_mem_en", n),  32'(ram_mem_en),  32'(v.e_en));
            if (v.e_ir || v.e_dr) begin
                check($sformatf("v%0d_mem_read", n), 32'(ram_mem_read), 32'(v.e_rd));
                check($sformatf("v%0d_ram_addr", n), ram_addr, v.e_ir ? v.ia : v.da);
                check($sformatf("v%0d_ram_din", n),  ram_data_in, v.e_dr ? v.dwd : 32'h0);
            end
            check($sformatf("v%0d_i_rsp_v", n),    32'(i_rsp_valid), 32'(v.e_iv));
            check($sformatf("v%0d_i_rsp_data", n), i_rsp_data,      v.e_idata);
            check($sformatf("v%0d_i_rsp_err", n),  32'(i_rsp_err),   32'(v.e_ierr));
            check($sformatf("v%0d_d_rsp_v", n),    32'(d_rsp_valid), 32'(v.e_dv));
            check($sformatf("v%0d_d_rsp_data", n), d_rsp_data,      v.e_ddata);
            check($sformatf("v%0d_d_rsp_err", n),  32'(d_rsp_err),   32'(v.e_derr));
        end

        // Reset mid-transaction: accepted fetch's response is dropped.
        @(negedge clk);
        drive(1, 260, 0, 0, 0, 0);
        #1;
        check("mid_i_ready", 32'(i_req_ready), 1);
        @(posedge clk);
        #1;
        check("mid_rsp_pending", 32'(i_rsp_valid), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("mid_rsp_dropped", 32'(i_rsp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        // Previous grant was fetch; reset must hand the first tie back to fetch.
        drive(1, 300, 1, 0, 300, 0);
        #1;
        check("post_rst_rsp_v", 32'({i_rsp_valid, d_rsp_valid}), 0);
        check("post_rst_tie_i", 32'(i_req_ready), 1);
        check("post_rst_tie_d", 32'(d_req_ready), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("post_rst_rsp_data", i_rsp_data, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BASE, default 256: first word address decoded to the RAM window.
REQ-002 SHALL have parameter SIZE, default 256: RAM window length in words; window is [BASE, BASE+SIZE).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  1  fetch request pending.
REQ-006 SHALL have port i_req_ready  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port i_addr  input  32  fetch word address.
REQ-008 SHALL have port i_rsp_valid  output  1  fetch response strobe.
REQ-009 SHALL have port i_rsp_data  output  32  fetch read data.
REQ-010 SHALL have port i_rsp_err  output  1  fetch address outside window.
REQ-011 SHALL have port d_req_valid  input  1  data request pending.
REQ-012 SHALL have port d_req_ready  output  1  data request accepted this cycle.
REQ-013 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-014 SHALL have port d_addr  input  32  data word address.
REQ-015 SHALL have port d_wdata  input  32  write data.
REQ-016 SHALL have port d_rsp_valid  output  1  data response strobe (reads and writes).
REQ-017 SHALL have port d_rsp_data  output  32  data read data; 0 for writes.
REQ-018 SHALL have port d_rsp_err  output  1  data address outside window.
REQ-019 SHALL have port ram_addr  output  32  RAM address.
REQ-020 SHALL have port ram_data_in  output  32  RAM write data.
REQ-021 SHALL have port ram_mem_read  output  1  RAM read (1) / write (0) select.
REQ-022 SHALL have port ram_mem_en  output  1  RAM enable.
REQ-023 SHALL have port ram_data_out  input  32  RAM read data, valid the cycle after a read issues.

Function
REQ-024 SHALL accept at most one request per cycle; a request is accepted in cycle T when its valid and ready are both 1.
REQ-025 SHALL drive ready combinationally: lone requester gets ready=1; with both valid, round-robin picks the port not granted last.
REQ-026 SHALL update the last-grant register only on acceptance.
REQ-027 SHALL drive ram_addr, ram_data_in, ram_mem_read and ram_mem_en combinationally from the accepted request in cycle T; with nothing accepted, ram_mem_en=0.
REQ-028 SHALL, for fetch grants, drive ram_mem_read=1 and ram_data_in=0.
REQ-029 SHALL, for data grants, drive ram_mem_read=!d_we and ram_data_in=d_wdata.
REQ-030 SHALL compute in-window as BASE <= addr < BASE+SIZE on the full 32-bit unsigned address, with no truncation.
REQ-031 SHALL, for an out-of-window accepted request, force ram_mem_en=0; the request is still accepted and answered.
REQ-032 SHALL register the response context (valid, port, is_write, err) at the end of T and assert exactly one rsp_valid in cycle T+1 for one cycle; responses have no backpressure.
REQ-033 SHALL, in T+1, drive rsp_data = ram_data_out for an in-window read; for writes or errors, rsp_data=0.
REQ-034 SHALL, in T+1, set rsp_err=1 exactly when the request was out of window.
REQ-035 SHALL support back-to-back acceptance: a new request may be accepted in T+1 while the T response is presented (1 transaction/cycle).
REQ-036 SHALL hold rsp_data, rsp_err = 0 on a port whose rsp_valid is 0.

Reset
REQ-037 SHALL, while rst=1, hold both ready outputs and ram_mem_en at 0.
REQ-038 SHALL, on rst assertion (asynchronous), clear response valid, port, is_write and err state, and set last-grant = data port so fetch wins the first tie.
REQ-039 SHALL discard a response in flight when rst asserts mid-transaction; no rsp_valid follows deassertion.

Verification
REQ-040 Fetch-only read: after writing 32'hDEADBEEF to word 300, fetch i_addr=300 in T -> ram_mem_en=1, ram_mem_read=1 in T; i_rsp_valid=1, i_rsp_data=32'hDEADBEEF, i_rsp_err=0 in T+1.
REQ-041 Tie after reset: both valid every cycle -> grants alternate I, D, I, D; one response per cycle from T+1.
REQ-042 Write then read same address: D write 511<-32'h1234 in T, D read 511 in T+1 -> d_rsp_valid, d_rsp_data=0 in T+1; d_rsp_data=32'h1234 in T+2.
REQ-043 Out of window: D write addr=255, then addr=512 -> ram_mem_en=0 both cycles; d_rsp_err=1 each; a later read of any word shows no change.
REQ-044 Reset mid-op: accept fetch at 260 in T, assert rst during T+1 -> i_rsp_valid=0; after release, first tie grants fetch.
